// File: rtl/pll_phase_stepper.sv
// rtl/pll_phase_stepper.sv - EHXPLLL dynamic phase-shift sequencer with lock supervision
//
// Ports:
//   clk_25MHz   board reference clock (never a PLL output)
//   reset       asynchronous, active-high
//   pll_locked  PLL LOCK, asynchronous to clk_25MHz
//   req_valid / req_ready / req_sel / req_dir / req_count
//               phase-move request handshake
//   done / err  one-cycle completion pulse; err marks an aborted move
//   busy        a move is in progress (SETUP, PULSE or GAP)
//   lock_ok     filtered lock status
//   phasesel / phasedir / phasestep
//               EHXPLLL dynamic phase-shift port
//   rd_sel / rd_phase
//               readback of the signed phase position of one output
module pll_phase_stepper #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 8,
  parameter int LOCK_FILT = 16,
  parameter int STEP_W    = 8
) (
  input  logic              clk_25MHz,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_count,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              lock_ok,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  input  logic [1:0]        rd_sel,
  output logic [15:0]       rd_phase
);

  localparam int T_MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int T_MAX   = (T_MAX_A > GAP_CYC) ? T_MAX_A : GAP_CYC;
  localparam int TMR_W   = (T_MAX < 2) ? 1 : $clog2(T_MAX);
  localparam int CNT_W   = $clog2(LOCK_FILT + 1);

  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] FILT_FULL  = CNT_W'(LOCK_FILT);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [STEP_W-1:0] remaining;
  logic [15:0]       acc [4];
  logic [15:0]       step_delta;

  logic              sync_q1;
  logic              sync_q2;
  logic [CNT_W-1:0]  lock_cnt;

  // ------------------------------------------------------------------
  // Lock filter: two-flop synchronizer, then a saturating run-length
  // counter. lock_ok is registered from the counter's next value so it
  // rises in the same edge the counter reaches LOCK_FILT.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      lock_cnt <= '0;
      lock_ok  <= 1'b0;
    end else begin
      sync_q1 <= pll_locked;
      sync_q2 <= sync_q1;
      if (!sync_q2) begin
        lock_cnt <= '0;
        lock_ok  <= 1'b0;
      end else begin
        if (lock_cnt != FILT_FULL) begin
          lock_cnt <= lock_cnt + 1'b1;
        end
        lock_ok <= (lock_cnt >= FILT_FULL - 1'b1);
      end
    end
  end

  // Each PULSE entry moves the selected output by one step in the
  // latched direction; 16-bit two's-complement wrap is intentional.
  assign step_delta = phasedir ? 16'h0001 : 16'hFFFF;

  // ------------------------------------------------------------------
  // Sequencer
  // ------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state     <= S_WAIT_LOCK;
      timer     <= '0;
      remaining <= '0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      phasesel  <= 2'd0;
      phasedir  <= 1'b0;
      phasestep <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc[i] <= 16'd0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        S_WAIT_LOCK: begin
          if (lock_ok) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            req_ready <= 1'b0;
          end
        end

        S_IDLE: begin
          // An accepted handshake is always honoured, even if lock is
          // lost in the same cycle; a non-zero move then aborts from
          // SETUP with done/err so the requester still gets a reply.
          if (req_valid && req_ready) begin
            phasesel <= req_sel;
            phasedir <= req_dir;
            if (req_count == '0) begin
              done      <= 1'b1;
              req_ready <= lock_ok;
              if (!lock_ok) begin
                state <= S_WAIT_LOCK;
              end
            end else begin
              remaining <= req_count;
              timer     <= SETUP_LOAD;
              busy      <= 1'b1;
              req_ready <= 1'b0;
              state     <= S_SETUP;
            end
          end else if (!lock_ok) begin
            req_ready <= 1'b0;
            state     <= S_WAIT_LOCK;
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_SETUP, S_PULSE, S_GAP: begin
          if (!lock_ok) begin
            // Abort: steps already entered stay in the accumulator,
            // anything still outstanding is dropped.
            phasestep <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            remaining <= '0;
            req_ready <= 1'b0;
            state     <= S_WAIT_LOCK;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            case (state)
              S_SETUP: begin
                state          <= S_PULSE;
                phasestep      <= 1'b1;
                timer          <= PULSE_LOAD;
                remaining      <= remaining - 1'b1;
                acc[phasesel]  <= acc[phasesel] + step_delta;
              end
              S_PULSE: begin
                state     <= S_GAP;
                phasestep <= 1'b0;
                timer     <= GAP_LOAD;
              end
              default: begin
                // S_GAP: next pulse reuses sel/dir without re-setup.
                if (remaining != '0) begin
                  state         <= S_PULSE;
                  phasestep     <= 1'b1;
                  timer         <= PULSE_LOAD;
                  remaining     <= remaining - 1'b1;
                  acc[phasesel] <= acc[phasesel] + step_delta;
                end else begin
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  req_ready <= 1'b1;
                end
              end
            endcase
          end
        end

        default: begin
          state     <= S_WAIT_LOCK;
          phasestep <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rd_phase = acc[rd_sel];

endmodule

// File: tb/tb_pll_phase_stepper.sv
// tb/tb_pll_phase_stepper.sv - self-checking bench for pll_phase_stepper
module tb_pll_phase_stepper;

  localparam int SETUP  = 2;
  localparam int PULSE  = 4;
  localparam int GAP    = 8;
  localparam int FILT   = 16;
  localparam int PERIOD = PULSE + GAP;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pll_locked, req_valid, req_ready, req_dir;
  logic [1:0]  req_sel, phasesel, rd_sel;
  logic [7:0]  req_count;
  logic        done, err, busy, lock_ok, phasedir, phasestep;
  logic [15:0] rd_phase;

  logic        f_pll_locked, f_req_valid, f_req_ready, f_req_dir;
  logic [1:0]  f_req_sel, f_phasesel, f_rd_sel;
  logic [7:0]  f_req_count;
  logic        f_done, f_err, f_busy, f_lock_ok, f_phasedir, f_phasestep;
  logic [15:0] f_rd_phase;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] model_acc [4];
  logic [15:0] f_model_acc [4];

  pll_phase_stepper u_dut (
    .clk_25MHz(clk), .reset(reset), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_count(req_count), .done(done), .err(err),
    .busy(busy), .lock_ok(lock_ok), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .rd_sel(rd_sel), .rd_phase(rd_phase)
  );

  // Short-timing instance so the 16-bit wrap is reachable in a modest run.
  pll_phase_stepper #(
    .SETUP_CYC(1), .PULSE_CYC(1), .GAP_CYC(1), .LOCK_FILT(2), .STEP_W(8)
  ) u_fast (
    .clk_25MHz(clk), .reset(reset), .pll_locked(f_pll_locked),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_sel(f_req_sel),
    .req_dir(f_req_dir), .req_count(f_req_count), .done(f_done), .err(f_err),
    .busy(f_busy), .lock_ok(f_lock_ok), .phasesel(f_phasesel), .phasedir(f_phasedir),
    .phasestep(f_phasestep), .rd_sel(f_rd_sel), .rd_phase(f_rd_phase)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd_all(input string tag);
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      n_cmp++;
      if (rd_phase !== model_acc[s]) begin
        n_bad++;
        $display("FAIL %s rd_phase[%0d]: got %h expected %h", tag, s, rd_phase, model_acc[s]);
      end
    end
  endtask

  // One request on the default instance; timing expectations come from
  // the accept-relative schedule: pulses start at 1+SETUP, period PULSE+GAP.
  task automatic run_req(input logic [1:0] sel, input logic dir, input int n, input bit pulse_chk);
    int exp_done, done_at, bad_wave, c;
    logic err_at, rdy_at, exp_ps, exp_busy, dir_seen;
    logic [1:0] sel_seen;
    exp_done = (n == 0) ? 1 : 1 + SETUP + n * PERIOD;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL req_ready_at_accept: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_sel = sel; req_dir = dir; req_count = 8'(n);
    tick;
    req_valid = 1'b0; req_sel = 2'($urandom); req_dir = 1'($urandom); req_count = 8'($urandom);
    sel_seen = phasesel; dir_seen = phasedir;
    done_at = -1; bad_wave = 0; c = 1; err_at = 1'bx; rdy_at = 1'bx;
    while (done_at < 0 && c <= exp_done + 40) begin
      exp_ps   = (n > 0) && (c >= 1 + SETUP) && (c < exp_done) && (((c - 1 - SETUP) % PERIOD) < PULSE);
      exp_busy = (n > 0) && (c < exp_done);
      if (phasestep !== exp_ps) bad_wave++;
      if (busy !== exp_busy) bad_wave++;
      if (done === 1'b1) begin
        done_at = c; err_at = err; rdy_at = req_ready;
      end else begin
        tick;
        c++;
      end
    end
    n_cmp++;
    if (done_at != exp_done) begin
      n_bad++;
      $display("FAIL done_cycle (sel=%0d dir=%0d n=%0d): got %0d expected %0d", sel, dir, n, done_at, exp_done);
    end
    n_cmp++;
    if (err_at !== 1'b0) begin
      n_bad++;
      $display("FAIL err_on_done: got %b expected 0", err_at);
    end
    n_cmp++;
    if (rdy_at !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_at_done: got %b expected 1", rdy_at);
    end
    n_cmp++;
    if (bad_wave != 0) begin
      n_bad++;
      $display("FAIL step_waveform (n=%0d): got %0d bad cycles expected 0", n, bad_wave);
    end
    n_cmp++;
    if ({sel_seen, dir_seen} !== {sel, dir}) begin
      n_bad++;
      $display("FAIL sel_dir_latch: got %b expected %b", {sel_seen, dir_seen}, {sel, dir});
    end
    model_acc[sel] = model_acc[sel] + (dir ? 16'(n) : 16'd0 - 16'(n));
    check_rd_all("request");
    if (pulse_chk) begin
      tick;
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL done_width: got %b expected 0", done);
      end
    end
  endtask

  task automatic f_run(input logic [1:0] sel, input logic dir, input int n);
    int c, done_at, pulses;
    logic err_at;
    f_req_valid = 1'b1; f_req_sel = sel; f_req_dir = dir; f_req_count = 8'(n);
    tick;
    f_req_valid = 1'b0;
    c = 1; done_at = -1; pulses = 0; err_at = 1'bx;
    while (done_at < 0 && c <= 2 * n + 40) begin
      if (f_phasestep === 1'b1) pulses++;
      if (f_done === 1'b1) begin
        done_at = c; err_at = f_err;
      end else begin
        tick;
        c++;
      end
    end
    n_cmp++;
    if (done_at != 2 + 2 * n || pulses != n || err_at !== 1'b0) begin
      n_bad++;
      $display("FAIL fast_request (n=%0d): got done %0d pulses %0d err %b expected done %0d pulses %0d err 0",
               n, done_at, pulses, err_at, 2 + 2 * n, n);
    end
    f_model_acc[sel] = f_model_acc[sel] + (dir ? 16'(n) : 16'd0 - 16'(n));
  endtask

  task automatic test_reset;
    logic exp_lock, exp_rdy;
    reset = 1'b1; pll_locked = 1'b0; req_valid = 1'b0; req_sel = 2'd0; req_dir = 1'b0;
    req_count = 8'd0; rd_sel = 2'd0;
    f_pll_locked = 1'b0; f_req_valid = 1'b0; f_req_sel = 2'd0; f_req_dir = 1'b0;
    f_req_count = 8'd0; f_rd_sel = 2'd0;
    for (int s = 0; s < 4; s++) begin
      model_acc[s] = 16'd0;
      f_model_acc[s] = 16'd0;
    end
    repeat (3) tick;
    n_cmp++;
    if ({req_ready, done, err, busy, lock_ok, phasesel, phasedir, phasestep} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0",
               {req_ready, done, err, busy, lock_ok, phasesel, phasedir, phasestep});
    end
    check_rd_all("reset");
    reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick;
      exp_lock = (c >= 5 + 2 + FILT);
      exp_rdy  = (c >= 5 + 3 + FILT);
      n_cmp++;
      if ({lock_ok, req_ready, done, err, busy, phasesel, phasedir, phasestep} !==
          {exp_lock, exp_rdy, 7'd0}) begin
        n_bad++;
        $display("FAIL lock_latency cycle %0d: got %b expected %b", c,
                 {lock_ok, req_ready, done, err, busy, phasesel, phasedir, phasestep}, {exp_lock, exp_rdy, 7'd0});
      end
      if (c == 5) begin
        pll_locked = 1'b1;
        f_pll_locked = 1'b1;
      end
    end
  endtask

  task automatic test_basic;
    run_req(2'd2, 1'b1, 3, 1'b1);
    run_req(2'd2, 1'b0, 5, 1'b1);
    rd_sel = 2'd2;
    #1;
    n_cmp++;
    if (rd_phase !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL rd_phase_minus2: got %h expected fffe", rd_phase);
    end
  endtask

  task automatic test_zero_count;
    run_req(2'd1, 1'b1, 0, 1'b1);
    run_req(2'd3, 1'b0, 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      run_req(2'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 5)), 1'($urandom));
    end
    run_req(2'd0, 1'b1, 2, 1'b1);
  endtask

  task automatic test_abort;
    logic [4:0] got, exp;
    run_req(2'd1, 1'b1, 0, 1'b1);
    req_valid = 1'b1; req_sel = 2'd1; req_dir = 1'b1; req_count = 8'd4;
    for (int c = 1; c <= 62; c++) begin
      tick;
      req_valid = 1'b0;
      exp[4] = (c >= 3) && (c < 19) && (((c - 3) % PERIOD) < PULSE);
      exp[3] = (c == 19);
      exp[2] = (c == 19);
      exp[1] = (c < 15 + 3) || (c >= 40 + 2 + FILT);
      exp[0] = (c >= 40 + 3 + FILT);
      got = {phasestep, done, err, lock_ok, req_ready};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL abort cycle %0d {step,done,err,lock,ready}: got %b expected %b", c, got, exp);
      end
      if (c == 15) pll_locked = 1'b0;
      if (c == 40) pll_locked = 1'b1;
    end
    model_acc[1] = model_acc[1] + 16'd2;
    check_rd_all("abort");
    run_req(2'd1, 1'b0, 1, 1'b1);
  endtask

  task automatic test_glitch;
    logic [3:0] got, exp;
    for (int c = 1; c <= 30; c++) begin
      tick;
      exp[3] = (c < 2 + 3) || (c >= 3 + 2 + FILT);
      exp[2] = (c < 2 + 4) || (c >= 3 + 3 + FILT);
      exp[1] = 1'b0;
      exp[0] = 1'b0;
      got = {lock_ok, req_ready, done, busy};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL glitch cycle %0d {lock,ready,done,busy}: got %b expected %b", c, got, exp);
      end
      if (c == 2) pll_locked = 1'b0;
      if (c == 3) pll_locked = 1'b1;
    end
    run_req(2'd3, 1'b1, 2, 1'b1);
  endtask

  task automatic test_wrap;
    int c;
    c = 0;
    while (f_req_ready !== 1'b1 && c < 50) begin
      tick;
      c++;
    end
    n_cmp++;
    if (f_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fast_ready: got %b expected 1", f_req_ready);
    end
    f_run(2'd1, 1'b1, 3);
    f_run(2'd1, 1'b0, 5);
    for (int i = 0; i < 128; i++) f_run(2'd1, 1'b1, 255);
    f_run(2'd1, 1'b1, 130);
    for (int s = 0; s < 4; s++) begin
      f_rd_sel = 2'(s);
      #1;
      n_cmp++;
      if (f_rd_phase !== f_model_acc[s]) begin
        n_bad++;
        $display("FAIL wrap rd_phase[%0d]: got %h expected %h", s, f_rd_phase, f_model_acc[s]);
      end
    end
    f_rd_sel = 2'd1;
    #1;
    n_cmp++;
    if (f_rd_phase !== 16'h8000) begin
      n_bad++;
      $display("FAIL wrap_negative: got %h expected 8000", f_rd_phase);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_count;
    test_back_to_back;
    test_abort;
    test_glitch;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
